// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding,
// requester count, select width and the one-hot grant helper.
package mux_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search over four requesters, starting
// at ptr and wrapping modulo 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from farthest to nearest offset so the nearest set bit wins.
  always_comb begin
    winner = 2'd0;
    any    = 1'b0;
    idx    = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 mux arbiter with a registered single-word output stage.
// Optional burst locking is enabled by defining RR_MUX_ARBITER_LOCK_EN.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] din,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]   last,
`endif
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  state_e           state_q;
  logic [N_REQ-1:0] ack_q;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q;
  logic             busy_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             sel_a, sel_b;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign sel_a = winner[1];
  assign sel_b = winner[0];

  // 4-to-1 data select: A is the high select bit, B the low one.
  always_comb begin
    data_d = din[0 +: W];
    case ({sel_a, sel_b})
      2'b00:   data_d = din[0*W +: W];
      2'b01:   data_d = din[1*W +: W];
      2'b10:   data_d = din[2*W +: W];
      2'b11:   data_d = din[3*W +: W];
      default: data_d = din[0*W +: W];
    endcase
  end

  // Next search start: hold on the winner while its burst is still open.
  always_comb begin
    ptr_d = winner + 2'd1;
`ifdef RR_MUX_ARBITER_LOCK_EN
    if (!last[winner]) begin
      ptr_d = winner;
    end else begin
      ptr_d = winner + 2'd1;
    end
`endif
  end

  // Capture/hold FSM; ack is a one-cycle pulse on each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= {N_REQ{1'b0}};
      data_q  <= {W{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      ack_q <= {N_REQ{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            state_q <= ST_BUSY;
            data_q  <= data_d;
            sel_q   <= winner;
            ack_q   <= onehot4(winner);
            ptr_q   <= ptr_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_rr_mux_arbiter;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic           out_ready;
  logic [3:0]     ack;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     sel;
  logic           busy;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic [3:0]     last;
`endif

  rr_mux_arbiter #(.W(W), .N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
`ifdef RR_MUX_ARBITER_LOCK_EN
    .last      (last),
`endif
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: holding a word or not, plus search start.
  bit         m_full;
  int         m_ptr;
  logic [W-1:0] m_data;
  int         m_sel;
  logic [3:0] m_ack;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int win;
    bit lst;
    m_ack = 4'b0000;
    if (rst) begin
      m_full = 1'b0; m_ptr = 0; m_data = '0; m_sel = 0;
    end else if (!m_full) begin
      win = -1;
      for (int k = 0; k < 4; k++)
        if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      if (win >= 0) begin
        m_data = din[win*W +: W];
        m_sel  = win;
        m_ack  = 4'(1 << win);
        m_full = 1'b1;
        lst = 1'b1;
`ifdef RR_MUX_ARBITER_LOCK_EN
        lst = last[win];
`endif
        m_ptr = lst ? (win + 1) % 4 : win;
      end
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("ack", ack, m_ack);
    check_val("out_valid", out_valid, m_full);
    check_val("busy", busy, m_full);
    check_val("sel", sel, m_sel);
    check_val("out_data", out_data, m_data);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  int grants[$];
  logic [W-1:0] held;

  initial begin
    rst = 1'b1; req = 4'b0000; din = '0; out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
    last = 4'b1111;
`endif
    step(); step();
    check_val("rst_state", {ack, out_data, out_valid, sel, busy}, 64'd0);
    rst = 1'b0;

    // single request from requester 2
    req = 4'b0100; din = 32'h00A5_0000; out_ready = 1'b1;
    step();
    check_val("single_ack", ack, 4'b0100);
    check_val("single_data", out_data, 8'hA5);
    check_val("single_sel", sel, 2'd2);
    check_val("single_valid", out_valid, 1'b1);
    req = 4'b0000;
    step();
    check_val("single_idle", out_valid, 1'b0);

    // round-robin with all requesters asserted
    do_reset();
    req = 4'b1111; din = 32'h4433_2211; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ack != 4'b0000) grants.push_back(int'(sel));
    end
    check_val("rr_count", grants.size(), 5);
    for (int g = 0; g < 5 && g < grants.size(); g++)
      check_val("rr_order", grants[g], g % 4);

    // backpressure on a word from requester 1
    do_reset();
    req = 4'b0010; din = 32'h0000_3C00; out_ready = 1'b0;
    step();
    held = out_data;
    check_val("bp_capture", held, 8'h3C);
    req = 4'b1000; din = 32'h7700_0000;
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("bp_hold_data", out_data, held);
      check_val("bp_no_ack", ack, 4'b0000);
      check_val("bp_sel", sel, 2'd1);
    end
    req = 4'b0000; out_ready = 1'b1;
    step();
    check_val("bp_release", out_valid, 1'b0);

    // wrap: ptr at 3, only requester 0 -> winner 0, then ptr 1
    do_reset();
    req = 4'b0100; step(); req = 4'b0000; step();
    req = 4'b0001; step();
    check_val("wrap_win", sel, 2'd0);
    req = 4'b1111; step(); step();
    check_val("wrap_next", sel, 2'd1);

    // reset while holding a word
    req = 4'b0000; out_ready = 1'b0; step();
    req = 4'b1000; step();
    check_val("rb_busy", out_valid, 1'b1);
    rst = 1'b1; step();
    check_val("rb_cleared", {ack, out_data, out_valid, sel, busy}, 64'd0);
    rst = 1'b0; req = 4'b0010; out_ready = 1'b1;
    step();
    check_val("rb_regrant", ack, 4'b0010);

`ifdef RR_MUX_ARBITER_LOCK_EN
    // burst locking on requester 0
    do_reset();
    req = 4'b0011; out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      last = (g < 2) ? 4'b1110 : 4'b1111;
      step();
      check_val("lock_grant", sel, (g < 3) ? 2'd0 : 2'd1);
      step();
    end
    last = 4'b1111;
`endif

    // random traffic
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = 4'($urandom);
      din       = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef RR_MUX_ARBITER_LOCK_EN
      last      = 4'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter W, default 8, data width per requester in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters; fixed at 4, other values unsupported.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  request, bit i = requester i holds a valid word.
REQ-006 din  input  4*W  requester i data at bits [i*W +: W]; held stable while req[i]=1.
REQ-007 ack  output  4  one-hot, one-cycle pulse: word of requester i captured.
REQ-008 out_data  output  W  registered selected word.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  downstream accepts out_data when out_valid=1.
REQ-011 sel  output  2  index of last granted requester (bit1 = A, bit0 = B select convention).
REQ-012 busy  output  1  high in BUSY state.

Function
REQ-013 FSM SHALL have two states: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 In IDLE with req!=0, winner = first set req bit searching ptr, ptr+1, ... mod 4; at the edge: out_data<=winner slice, sel<=winner, ack<=onehot(winner), state<=BUSY.
REQ-015 In IDLE with req=0, all registers hold; ack=0.
REQ-016 Latency: req sampled at edge E -> out_valid and ack high in the cycle after E; ack deasserts after exactly one cycle.
REQ-017 In BUSY, out_data and sel SHALL be stable; req SHALL be ignored; no ack issued.
REQ-018 In BUSY with out_ready=1, state<=IDLE at that edge; with out_ready=0, remain BUSY indefinitely.
REQ-019 Throughput: at most one word per two cycles (one bubble IDLE cycle per transfer).
REQ-020 ptr update on capture: ptr <= (winner+1) mod 4, wrap 3->0 (subject to REQ-026).
REQ-021 ack SHALL never have more than one bit set; ack only for a requester with req=1 at capture.
REQ-022 Requester SHALL drop req or present a new word within the cycle after ack; arbiter evaluates it no earlier than the next IDLE cycle.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 rst=1 at an edge: state=IDLE, out_valid=0, out_data=0, sel=0, ack=0, ptr=0, busy=0; overrides all other events that edge.
REQ-025 Reset mid-BUSY SHALL discard the held word without further ack or handshake.

Configuration
REQ-026 Macro RR_MUX_ARBITER_LOCK_EN: when defined, add input last [4] (bit i = word of requester i is final of its burst); on capture ptr<=winner if last[winner]=0, else (winner+1) mod 4; when undefined, port last absent and REQ-020 applies unconditionally.

Structure
REQ-027 Shared package mux_arb_pkg SHALL hold FSM state encoding (IDLE=0, BUSY=1), N_REQ and select width constant 2.
REQ-028 Winner search SHALL be a combinational sub-module rr_pick4 (inputs req, ptr; outputs winner index, any).
REQ-029 Datapath selection SHALL reuse the team 4-to-1 select convention driven by winner index.

Verification
REQ-030 Single request: req=4'b0100, din slice2=8'hA5, out_ready=1 -> next cycle ack=4'b0100, out_data=8'hA5, sel=2, out_valid=1; then IDLE.
REQ-031 Round-robin: req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0 with one IDLE bubble between each.
REQ-032 Backpressure: capture from requester 1, out_ready=0 for 5 cycles -> out_valid, out_data, sel stable, no ack; out_ready=1 -> IDLE next edge.
REQ-033 Wrap: ptr=3, req=4'b0001 -> winner 0, ptr becomes 1.
REQ-034 Reset in BUSY: rst=1 for one cycle -> all outputs 0, next req=4'b0010 granted with ptr search starting at 0.
REQ-035 With RR_MUX_ARBITER_LOCK_EN: req=4'b0011, last[0]=0 for two words then 1 -> requester 0 granted three consecutive times, then requester 1.
